// File: rtl/tanh_lut_writer.sv
// Loads the tanh lookup table into RAM from a valid/ready word stream, then verifies the
// trailing checksum and (optionally) table monotonicity before declaring the table usable.
module tanh_lut_writer #(
    parameter int AW         = 10,
    parameter int DW         = 16,
    parameter bit CHECK_MONO = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          table_valid,
    output logic          error,
    output logic [1:0]    err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         sum_q, sum_d;
    logic signed [DW-1:0]  prev_q, prev_d;
    logic                  mono_q, mono_d;
    logic                  mem_we_q, mem_we_d;
    logic [AW-1:0]         mem_addr_q, mem_addr_d;
    logic [DW-1:0]         mem_wdata_q, mem_wdata_d;
    logic                  done_q, done_d;
    logic                  table_valid_q, table_valid_d;
    logic                  error_q, error_d;
    logic [1:0]            err_code_q, err_code_d;

    logic                  hs;
    logic                  fail_sum;
    logic                  fail_mono;

    // Ready depends only on the state, so a producer never waits on its own valid.
    assign s_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign busy    = s_ready;
    assign hs      = s_valid && s_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sum_d         = sum_q;
        prev_d        = prev_q;
        mono_d        = mono_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        done_d        = 1'b0;
        table_valid_d = table_valid_q;
        error_d       = error_q;
        err_code_d    = err_code_q;
        fail_sum      = 1'b0;
        fail_mono     = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (abort) begin
                    state_d       = S_IDLE;
                    table_valid_d = 1'b0;
                    error_d       = 1'b0;
                    err_code_d    = 2'b00;
                end else if (hs) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q;
                    mem_wdata_d = s_data;
                    sum_d       = sum_q + s_data;
                    if ((cnt_q != '0) && ($signed(s_data) < prev_q)) begin
                        mono_d = 1'b1;
                    end
                    prev_d = $signed(s_data);
                    cnt_d  = cnt_q + AW'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d       = S_IDLE;
                    table_valid_d = 1'b0;
                    error_d       = 1'b0;
                    err_code_d    = 2'b00;
                end else if (hs) begin
                    // The checksum word is consumed here and never reaches the RAM.
                    fail_sum  = (s_data != sum_q);
                    fail_mono = mono_q && CHECK_MONO;
                    if (!fail_sum && !fail_mono) begin
                        state_d       = S_DONE;
                        done_d        = 1'b1;
                        table_valid_d = 1'b1;
                    end else begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = {fail_mono, fail_sum};
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d       = S_LOAD;
                    table_valid_d = 1'b0;
                    error_d       = 1'b0;
                    err_code_d    = 2'b00;
                    cnt_d         = '0;
                    sum_d         = '0;
                    mono_d        = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            sum_q         <= '0;
            prev_q        <= '0;
            mono_q        <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            done_q        <= 1'b0;
            table_valid_q <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= 2'b00;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sum_q         <= sum_d;
            prev_q        <= prev_d;
            mono_q        <= mono_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            done_q        <= done_d;
            table_valid_q <= table_valid_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign done        = done_q;
    assign table_valid = table_valid_q;
    assign error       = error_q;
    assign err_code    = err_code_q;

endmodule
